alu_cmd_sequencer: RTL

- Upstream stage of the alu block.
- Accepts operand/operator commands over a valid/ready channel and buffers them in a small FIFO.
- Issues one command at a time to the alu via its data_in/input_a/input_b/operator inputs, waits the fixed alu latency, captures result, and returns it tagged on a valid/ready response channel.
- Exactly one command is in flight at the alu at any time.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 49 ++++
 rtl/alu_cmd_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared widths, FSM state type and command payload for the alu command sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned OP_W            = 3;
  localparam int unsigned RES_W           = 16;
  localparam int unsigned TAG_W           = 4;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned ALU_LATENCY_DEF = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } seq_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_seq_if.sv
// Command, alu-side and response signals of the sequencer, bundled with modports.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic              data_in;
  logic [DATA_W-1:0] input_a;
  logic [DATA_W-1:0] input_b;
  logic [OP_W-1:0]   operator;
  logic [RES_W-1:0]  result;
  logic              resp_valid;
  logic              resp_ready;
  logic [RES_W-1:0]  resp_result;
  logic [OP_W-1:0]   resp_op;
  logic [TAG_W-1:0]  resp_tag;
  logic              busy;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, result, resp_ready,
    output cmd_ready, data_in, input_a, input_b, operator,
           resp_valid, resp_result, resp_op, resp_tag, busy
  );

  // Producer/consumer/alu side
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, result, resp_ready,
    input  cmd_ready, data_in, input_a, input_b, operator,
           resp_valid, resp_result, resp_op, resp_tag, busy
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head entry is presented combinationally.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  alu_cmd_t         i_data,
  output alu_cmd_t         o_data_c,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  alu_cmd_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_data_c  = r_mem[r_rd_ptr];
  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues alu commands, issues one at a time, waits the alu latency and returns tagged results.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned ALU_LATENCY = ALU_LATENCY_DEF
) (
  input logic      clock,
  input logic      reset,
  alu_seq_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  seq_state_t        r_state;
  seq_state_t        w_state_next;
  logic              w_push;
  logic              w_pop;
  alu_cmd_t          w_cmd_in;
  alu_cmd_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_next;

  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_data_in;
  logic [DATA_W-1:0] r_input_a;
  logic [DATA_W-1:0] r_input_b;
  logic [OP_W-1:0]   r_operator;
  logic [TAG_W-1:0]  r_tag;
  logic [TAG_W-1:0]  r_tag_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_resp_valid;
  logic [RES_W-1:0]  r_resp_result;
  logic [OP_W-1:0]   r_resp_op;
  logic [TAG_W-1:0]  r_resp_tag;

  assign w_push       = bus.cmd_valid && r_cmd_ready;
  assign w_cmd_in     = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, tag: r_tag_cnt};
  assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (w_cmd_in),
    .o_data_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and FIFO pop
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (r_wait_cnt == '0) w_state_next = RESP;
      RESP:    if (bus.resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Registered outputs, in-flight command and response capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_data_in     <= 1'b0;
      r_input_a     <= '0;
      r_input_b     <= '0;
      r_operator    <= '0;
      r_tag         <= '0;
      r_tag_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_result <= '0;
      r_resp_op     <= '0;
      r_resp_tag    <= '0;
    end else begin
      r_cmd_ready  <= (w_count_next != CNT_W'(DEPTH));
      r_busy       <= (w_count_next != '0) || (w_state_next != IDLE);
      r_data_in    <= (w_state_next == ISSUE);
      r_resp_valid <= (w_state_next == RESP);
      if (w_push) begin
        r_tag_cnt <= r_tag_cnt + TAG_W'(1);
      end
      if (w_pop) begin
        r_input_a  <= w_head.a;
        r_input_b  <= w_head.b;
        r_operator <= w_head.op;
        r_tag      <= w_head.tag;
      end
      if (r_state == ISSUE) begin
        r_wait_cnt <= WAIT_W'(ALU_LATENCY - 1);
      end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
      end
      if ((r_state == WAIT) && (r_wait_cnt == '0)) begin
        r_resp_result <= bus.result;
        r_resp_op     <= r_operator;
        r_resp_tag    <= r_tag;
      end
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.busy        = r_busy;
  assign bus.data_in     = r_data_in;
  assign bus.input_a     = r_input_a;
  assign bus.input_b     = r_input_b;
  assign bus.operator    = r_operator;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_result = r_resp_result;
  assign bus.resp_op     = r_resp_op;
  assign bus.resp_tag    = r_resp_tag;

endmodule
